// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory.
// Inserts WAIT_STATES access cycles before pready; out-of-range addresses complete with pslverr.
module apb_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]    WS_LIM    = CNT_W'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic                  setup_err;
  logic [CNT_W-1:0]      cnt_inc;

  assign setup_err = ({1'b0, paddr} >= DEPTH_LIM);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Next-state, counter, memory write and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_d     = mem_q;

    case (state_q)
      S_IDLE: begin
        if (pselx && !penable) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          addr_d  = IDX_W'(paddr);
          write_d = pwrite;
          err_d   = setup_err;
          // Zero wait states: the response is loaded on the setup edge itself
          if (WS_LIM == '0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            if (!pwrite && !setup_err) begin
              prdata_d = mem_q[IDX_W'(paddr)];
            end
          end
        end
      end
      S_ACCESS: begin
        if (!pselx) begin
          state_d = S_IDLE;
        end else if (pready_q) begin
          state_d = S_IDLE;
          if (write_q && !err_q) begin
            mem_d[addr_q] = pwdata;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == WS_LIM) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q && !err_q) begin
              prdata_d = mem_q[addr_q];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched transfer attributes, outputs and memory
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      mem_q     <= mem_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: four instances with WAIT_STATES 0, 1, 3 and 7
// share one APB bus; each instance has its own select line.
module tb_apb_mem_slave;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 16;
  localparam int unsigned NDUT = 4;

  logic            pclk = 1'b0;
  logic            preset;
  logic [NDUT-1:0] psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready_a  [NDUT];
  logic [DW-1:0]   prdata_a  [NDUT];
  logic            pslverr_a [NDUT];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 pclk = ~pclk;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      apb_mem_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7)
      ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .pselx  (psel[g]),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready_a[g]),
        .prdata (prdata_a[g]),
        .pslverr(pslverr_a[g])
      );
    end
  endgenerate

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : (d == 2) ? 3 : 7;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (n) step();
  endtask

  task automatic check_quiet(input string tag, input int d);
    check({tag, " pready"},  DW'(pready_a[d]),  '0);
    check({tag, " pslverr"}, DW'(pslverr_a[d]), '0);
    check({tag, " prdata"},  prdata_a[d],       '0);
  endtask

  // Full transfer on instance d; returns in the cycle after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input logic exp_err);
    string tag;
    int    lat;
    tag = $sformatf("%s d%0d a%0d", wr ? "wr" : "rd", d, a);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    step();
    penable = 1'b1;
    lat = 0;
    while (pready_a[d] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, DW'(lat), DW'(ws_of(d)));
    check({tag, " pready"},  DW'(pready_a[d]), DW'(1));
    check({tag, " pslverr"}, DW'(pslverr_a[d]), DW'(exp_err));
    check({tag, " prdata"},  prdata_a[d], exp_rd);
    step();
    check({tag, " pready_drop"}, DW'(pready_a[d]), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset  = 1'b1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;

    // Reset held for two cycles with random bus activity
    for (int c = 0; c < 2; c++) begin
      psel    = NDUT'($urandom);
      penable = 1'($urandom);
      pwrite  = 1'($urandom);
      paddr   = AW'($urandom);
      pwdata  = $urandom;
      step();
      for (int d = 0; d < NDUT; d++) check_quiet($sformatf("reset c%0d d%0d", c, d), d);
    end
    preset = 1'b0;
    idle(1);
    xfer(1, 1'b0, 8'd5, '0, 32'h0, 1'b0);
    idle(1);

    // Write/read with one wait state
    xfer(1, 1'b1, 8'd3, 32'hDEADBEEF, 32'h0, 1'b0);
    idle(1);
    xfer(1, 1'b0, 8'd3, '0, 32'hDEADBEEF, 1'b0);
    idle(1);

    // Last legal address with zero and seven wait states
    xfer(0, 1'b1, 8'd15, 32'hA5A5A5A5, 32'h0, 1'b0);
    idle(1);
    xfer(0, 1'b0, 8'd15, '0, 32'hA5A5A5A5, 1'b0);
    idle(1);
    xfer(3, 1'b1, 8'd15, 32'hA5A5A5A5, 32'h0, 1'b0);
    idle(1);
    xfer(3, 1'b0, 8'd15, '0, 32'hA5A5A5A5, 1'b0);
    idle(1);

    // Out-of-range addresses: error response, memory untouched
    xfer(1, 1'b1, 8'd16, 32'h12345678, 32'h0, 1'b1);
    idle(1);
    xfer(1, 1'b0, 8'd16, '0, 32'h0, 1'b1);
    idle(1);
    xfer(1, 1'b0, 8'd0, '0, 32'h0, 1'b0);
    idle(1);
    xfer(1, 1'b0, 8'd255, '0, 32'h0, 1'b1);
    idle(1);

    // Abort: pselx dropped in T2 of a three-wait-state write
    psel    = '0;
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'd2;
    pwdata  = 32'h1;
    step();
    penable = 1'b1;
    check("abort T1 pready", DW'(pready_a[2]), '0);
    step();
    psel    = '0;
    penable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("abort post c%0d pready", c), DW'(pready_a[2]), '0);
    end
    xfer(2, 1'b0, 8'd2, '0, 32'h0, 1'b0);
    idle(1);

    // Reset in T2 of a write; reset also clears previously written words
    xfer(2, 1'b1, 8'd9, 32'h99, 32'h0, 1'b0);
    psel    = '0;
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'd4;
    pwdata  = 32'h2;
    step();
    penable = 1'b1;
    step();
    preset = 1'b1;
    step();
    preset = 1'b0;
    check_quiet("reset mid T3", 2);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("reset mid post c%0d pready", c), DW'(pready_a[2]), '0);
    end
    idle(1);
    xfer(2, 1'b0, 8'd4, '0, 32'h0, 1'b0);
    xfer(2, 1'b0, 8'd9, '0, 32'h0, 1'b0);
    idle(1);

    // Back-to-back alternating write/read-back, three wait states
    for (int i = 1; i <= 4; i++) begin
      xfer(2, 1'b1, AW'(i), DW'(i * 32'h11), 32'h0, 1'b0);
      xfer(2, 1'b0, AW'(i), '0, DW'(i * 32'h11), 1'b0);
    end

    // penable without a setup phase: must be ignored by every instance
    psel    = '1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'd1;
    pwdata  = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int d = 0; d < NDUT; d++)
        check($sformatf("glitch c%0d d%0d pready", c, d), DW'(pready_a[d]), '0);
    end

    // Second back-to-back burst, zero wait states
    for (int i = 5; i <= 8; i++) begin
      xfer(0, 1'b1, AW'(i), DW'(i * 32'h11), 32'h0, 1'b0);
      xfer(0, 1'b0, AW'(i), '0, DW'(i * 32'h11), 1'b0);
    end
    xfer(2, 1'b0, 8'd1, '0, 32'h11, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
